// File: rtl/thor2024_fetch_buffer_pkg.sv
// Thor2024pkg: shared fetch-path types, branch opcodes and helpers.
package Thor2024pkg;
  typedef logic [31:0] pc_address_t;
  localparam pc_address_t RSTPC = 32'hFFFD0000;
  localparam pc_address_t INSN_BYTES = 32'd5;
  localparam logic [6:0] OP_BEQ = 7'd38;
  localparam logic [6:0] OP_BNE = 7'd39;
  localparam logic [6:0] OP_BLT = 7'd40;
  localparam logic [6:0] OP_BGE = 7'd41;
  typedef struct packed {
    logic v;
    pc_address_t pc;
    logic [39:0] instr;
  } fetchbuf_slot_t;
  function automatic logic fnIsBackBr(input logic [39:0] insn);
    return insn[39] && (insn[6:0] inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE});
  endfunction
  function automatic pc_address_t fnBrTarget(input pc_address_t pc, input logic [39:0] insn);
    return pc + {{15{insn[39]}}, insn[39:23]};
  endfunction
endpackage

// File: rtl/thor2024_fetch_buffer_pair.sv
// thor2024_fetch_pair: two fetch slots with pair load, in-order dequeue and stomp.
module thor2024_fetch_pair
  import Thor2024pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  pc_address_t ld_pc,
  input  logic [39:0] ld_instr0,
  input  logic [39:0] ld_instr1,
  input  logic [1:0]  deq_cnt,
  input  logic        stomp1,
  input  logic        stomp_all,
  output logic        v0,
  output logic        v1,
  output pc_address_t pc0,
  output pc_address_t pc1,
  output logic [39:0] instr0,
  output logic [39:0] instr1
);
  fetchbuf_slot_t s0_q, s0_d, s1_q, s1_d;
  logic kill0, kill1;
  // a single dequeue takes the second slot only once the first is already gone
  always_comb begin
    kill0 = (deq_cnt != 2'd0) | stomp_all | flush;
    kill1 = (deq_cnt >= 2'd2) | (deq_cnt == 2'd1 & ~s0_q.v) | stomp1 | stomp_all | flush;
    s0_d = load ? '{1'b1, ld_pc, ld_instr0} : '{s0_q.v & ~kill0, s0_q.pc, s0_q.instr};
    s1_d = load ? '{1'b1, ld_pc + INSN_BYTES, ld_instr1} : '{s1_q.v & ~kill1, s1_q.pc, s1_q.instr};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '{1'b0, RSTPC, 40'd0};
      s1_q <= '{1'b0, RSTPC, 40'd0};
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end
  assign v0 = s0_q.v;
  assign v1 = s1_q.v;
  assign pc0 = s0_q.pc;
  assign pc1 = s1_q.pc;
  assign instr0 = s0_q.instr;
  assign instr1 = s1_q.instr;
endmodule

// File: rtl/thor2024_fetch_buffer.sv
// thor2024_fetch_buffer: double-buffered A/B, C/D instruction pairs with backward-branch detection.
module thor2024_fetch_buffer
  import Thor2024pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  pc_address_t pc,
  input  logic        ic_hit,
  input  logic [39:0] ic_insn0,
  input  logic [39:0] ic_insn1,
  input  logic        irq,
  input  logic        branchmiss,
  input  logic [1:0]  enq_cnt,
  output logic        fetchbuf,
  output logic        fetchbufA_v,
  output logic        fetchbufB_v,
  output logic        fetchbufC_v,
  output logic        fetchbufD_v,
  output logic [39:0] fetchbufA_instr,
  output logic [39:0] fetchbufB_instr,
  output logic [39:0] fetchbufC_instr,
  output logic [39:0] fetchbufD_instr,
  output pc_address_t fetchbufA_pc,
  output pc_address_t fetchbufB_pc,
  output pc_address_t fetchbufC_pc,
  output pc_address_t fetchbufD_pc,
  output logic        backbrA,
  output logic        backbrB,
  output logic        backbrC,
  output logic        backbrD,
  output logic        branchback,
  output pc_address_t backpc
);
  logic fetchbuf_q, fetchbuf_d;
  logic f_v, s_v, f_bb, s_bb, f_br, load, load_ab, load_cd, load_act, other_alive, empty_n;
  logic [1:0] act_cnt;
  pc_address_t f_pc, s_pc;
  logic [39:0] f_instr, s_instr;
  assign backbrA = fnIsBackBr(fetchbufA_instr);
  assign backbrB = fnIsBackBr(fetchbufB_instr);
  assign backbrC = fnIsBackBr(fetchbufC_instr);
  assign backbrD = fnIsBackBr(fetchbufD_instr);
  always_comb begin
    f_v = fetchbuf_q ? fetchbufC_v : fetchbufA_v;
    s_v = fetchbuf_q ? fetchbufD_v : fetchbufB_v;
    f_bb = fetchbuf_q ? backbrC : backbrA;
    s_bb = fetchbuf_q ? backbrD : backbrB;
    f_pc = fetchbuf_q ? fetchbufC_pc : fetchbufA_pc;
    s_pc = fetchbuf_q ? fetchbufD_pc : fetchbufB_pc;
    f_instr = fetchbuf_q ? fetchbufC_instr : fetchbufA_instr;
    s_instr = fetchbuf_q ? fetchbufD_instr : fetchbufB_instr;
    f_br = f_v & f_bb;
    branchback = f_br | (s_v & s_bb);
    backpc = f_br ? fnBrTarget(f_pc, f_instr) : fnBrTarget(s_pc, s_instr);
    load = ic_hit & ~irq & ~branchmiss & ~branchback;
    load_ab = load & ~fetchbufA_v & ~fetchbufB_v;
    load_cd = load & ~load_ab & ~fetchbufC_v & ~fetchbufD_v;
    load_act = fetchbuf_q ? load_cd : load_ab;
    act_cnt = {1'b0, f_v} + {1'b0, s_v};
    // a taken-back branch in the first slot stomps the second, so dequeuing it empties the pair
    empty_n = f_br ? (enq_cnt != 2'd0) : (enq_cnt >= act_cnt);
    other_alive = fetchbuf_q ? ((fetchbufA_v | fetchbufB_v) & ~branchback) | load_ab
                             : ((fetchbufC_v | fetchbufD_v) & ~branchback) | load_cd;
    fetchbuf_d = ~branchmiss & (fetchbuf_q ^ (empty_n & ~load_act & ((act_cnt != 2'd0) | other_alive)));
  end
  always_ff @(posedge clk) fetchbuf_q <= rst ? 1'b0 : fetchbuf_d;
  assign fetchbuf = fetchbuf_q;
  thor2024_fetch_pair u_ab (
    .clk(clk), .rst(rst), .flush(branchmiss), .load(load_ab), .ld_pc(pc),
    .ld_instr0(ic_insn0), .ld_instr1(ic_insn1),
    .deq_cnt(fetchbuf_q ? 2'd0 : enq_cnt),
    .stomp1(~fetchbuf_q & f_br), .stomp_all(fetchbuf_q & branchback),
    .v0(fetchbufA_v), .v1(fetchbufB_v), .pc0(fetchbufA_pc), .pc1(fetchbufB_pc),
    .instr0(fetchbufA_instr), .instr1(fetchbufB_instr)
  );
  thor2024_fetch_pair u_cd (
    .clk(clk), .rst(rst), .flush(branchmiss), .load(load_cd), .ld_pc(pc),
    .ld_instr0(ic_insn0), .ld_instr1(ic_insn1),
    .deq_cnt(fetchbuf_q ? enq_cnt : 2'd0),
    .stomp1(fetchbuf_q & f_br), .stomp_all(~fetchbuf_q & branchback),
    .v0(fetchbufC_v), .v1(fetchbufD_v), .pc0(fetchbufC_pc), .pc1(fetchbufD_pc),
    .instr0(fetchbufC_instr), .instr1(fetchbufD_instr)
  );
endmodule
